// File: rtl/clkdiv_ctrl.sv
// Run-time programmable clock divider with clean start/stop and boundary-aligned retiming.
// Optional define CLKDIV_CTRL_PERIOD_COUNT_EN adds the operiods rising-edge counter output.
module clkdiv_ctrl #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEFAULT_HALF = 250000,
    parameter int unsigned MIN_HALF     = 1
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             ienable,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] ihalf,
    output logic             oready,
    output logic             oclk,
    output logic             otick,
    output logic [WIDTH-1:0] ohalf,
    output logic [1:0]       ostate
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
    ,
    output logic [15:0]      operiods
`endif
);

    // state    | meaning
    // IDLE     | divided clock parked low, counter cleared
    // RUN      | counting half-periods, oclk toggling
    // STOPPING | stop requested while high; finish the high phase, then park

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        RUN      = 2'b01,
        STOPPING = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_HALF);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_HALF);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);

    state_t           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] pend_half;
    logic             pend_v;
    logic             boundary;
    logic             accept;
    logic [WIDTH-1:0] req_half;

    always_comb begin
        boundary = (count == (ohalf - ONE_W));
        accept   = ivalid & oready;
        req_half = (ihalf < MIN_W) ? MIN_W : ihalf;
    end

    assign ostate = state;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state     <= IDLE;
            count     <= '0;
            oclk      <= 1'b0;
            otick     <= 1'b0;
            oready    <= 1'b1;
            ohalf     <= DEF_W;
            pend_half <= DEF_W;
            pend_v    <= 1'b0;
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
            operiods  <= '0;
`endif
        end else begin
            otick  <= 1'b0;
            // ready stays low through the apply edge and recovers one edge later
            oready <= ~pend_v & ~accept;

            case (state)
                IDLE: begin
                    count <= '0;
                    oclk  <= 1'b0;
                    if (pend_v) begin
                        ohalf  <= pend_half;
                        pend_v <= 1'b0;
                    end
                    if (ienable) begin
                        state <= RUN;
                    end
                end

                RUN: begin
                    if (!ienable && !oclk) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (boundary) begin
                        count <= '0;
                        oclk  <= ~oclk;
                        otick <= 1'b1;
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
                        if (!oclk) begin
                            operiods <= operiods + 16'd1;
                        end
`endif
                        if (pend_v) begin
                            ohalf  <= pend_half;
                            pend_v <= 1'b0;
                        end
                        // disable seen exactly at the falling boundary: park immediately
                        if (!ienable) begin
                            state <= IDLE;
                        end
                    end else begin
                        count <= count + ONE_W;
                        if (!ienable) begin
                            state <= STOPPING;
                        end
                    end
                end

                STOPPING: begin
                    if (boundary) begin
                        count <= '0;
                        oclk  <= 1'b0;
                        otick <= 1'b1;
                        if (pend_v) begin
                            ohalf  <= pend_half;
                            pend_v <= 1'b0;
                        end
                        state <= ienable ? RUN : IDLE;
                    end else begin
                        count <= count + ONE_W;
                        if (ienable) begin
                            state <= RUN;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                    oclk  <= 1'b0;
                end
            endcase

            if (accept) begin
                pend_half <= req_half;
                pend_v    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_ctrl.sv
// Self-checking bench for clkdiv_ctrl: directed literal checks plus randomized
// stimulus compared every cycle against a half-period-level behavioural model.
module tb_clkdiv_ctrl;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEF   = 4;
    localparam int unsigned MINH  = 1;

    logic             iclk = 1'b0;
    logic             irst_n;
    logic             ienable;
    logic             ivalid;
    logic [WIDTH-1:0] ihalf;
    logic             oready;
    logic             oclk;
    logic             otick;
    logic [WIDTH-1:0] ohalf;
    logic [1:0]       ostate;
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
    logic [15:0]      operiods;
`endif

    int checks = 0;
    int errors = 0;

    clkdiv_ctrl #(
        .WIDTH(WIDTH),
        .DEFAULT_HALF(DEF),
        .MIN_HALF(MINH)
    ) dut (
        .iclk(iclk),
        .irst_n(irst_n),
        .ienable(ienable),
        .ivalid(ivalid),
        .ihalf(ihalf),
        .oready(oready),
        .oclk(oclk),
        .otick(otick),
        .ohalf(ohalf),
        .ostate(ostate)
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
        ,
        .operiods(operiods)
`endif
    );

    always #5 iclk = ~iclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks the output level, how many cycles of the current
    // half have elapsed, the active half length and a queue of accepted requests.
    int              m_mode;      // 0 parked, 1 running, 2 finishing a high phase
    longint unsigned m_elapsed;
    longint unsigned m_half;
    longint unsigned m_pend[$];
    bit              m_clk;
    bit              m_tick;
    bit              m_ready;
    int unsigned     m_periods;

    always @(posedge iclk or negedge irst_n) begin : model
        bit              took;
        bit              had_pend;
        bit              half_over;
        longint unsigned req;
        if (!irst_n) begin
            m_mode    = 0;
            m_elapsed = 0;
            m_half    = DEF;
            m_pend.delete();
            m_clk     = 1'b0;
            m_tick    = 1'b0;
            m_ready   = 1'b1;
            m_periods = 0;
        end else begin
            took      = ivalid && m_ready;
            had_pend  = (m_pend.size() != 0);
            half_over = (m_mode != 0) && (m_elapsed + 1 == m_half);
            m_tick    = 1'b0;
            if (m_mode == 0) begin
                if (had_pend) m_half = m_pend.pop_front();
                if (ienable) m_mode = 1;
            end else if (m_mode == 1 && !ienable && !m_clk) begin
                m_mode    = 0;
                m_elapsed = 0;
            end else if (half_over) begin
                m_clk     = !m_clk;
                m_tick    = 1'b1;
                m_elapsed = 0;
                if (m_clk) m_periods++;
                if (had_pend) m_half = m_pend.pop_front();
                m_mode = ienable ? 1 : 0;
            end else begin
                m_elapsed++;
                m_mode = ienable ? 1 : 2;
            end
            if (took) begin
                req = longint'(ihalf);
                if (req < MINH) req = MINH;
                m_pend.push_back(req);
            end
            m_ready = !took && !had_pend;
        end
    end

    always @(negedge iclk) begin : compare
        chk("cmp_oclk",   {63'd0, oclk},   {63'd0, m_clk});
        chk("cmp_otick",  {63'd0, otick},  {63'd0, m_tick});
        chk("cmp_oready", {63'd0, oready}, {63'd0, m_ready});
        chk("cmp_ohalf",  {32'd0, ohalf},  m_half);
        chk("cmp_ostate", {62'd0, ostate}, 64'(m_mode));
`ifdef CLKDIV_CTRL_PERIOD_COUNT_EN
        chk("cmp_operiods", {48'd0, operiods}, 64'(m_periods & 32'hFFFF));
`endif
    end

    task automatic cycles_to_tick(input int bound, output int n);
        n = 0;
        while (n <= bound) begin
            @(negedge iclk);
            n++;
            if (otick) break;
        end
    endtask

    task automatic wait_idle(input int bound);
        int k;
        k = 0;
        while (ostate != 2'b00 && k < bound) begin
            @(negedge iclk);
            k++;
        end
    endtask

    initial begin : stim
        int  n;
        logic prev;
        irst_n  = 1'b0;
        ienable = 1'b0;
        ivalid  = 1'b0;
        ihalf   = '0;
        repeat (3) @(negedge iclk);
        irst_n = 1'b1;
        @(negedge iclk);
        chk("rst_state", {62'd0, ostate}, 64'd0);
        chk("rst_ready", {63'd0, oready}, 64'd1);
        chk("rst_half",  {32'd0, ohalf},  64'd4);
        chk("rst_clk",   {63'd0, oclk},   64'd0);

        // default half of 4: rise 4 cycles after RUN entry, then a tick every 4
        ienable = 1'b1;
        @(negedge iclk);
        chk("run_entry", {62'd0, ostate}, 64'd1);
        cycles_to_tick(20, n);
        chk("first_tick_lat", 64'(n), 64'd4);
        chk("first_rise", {63'd0, oclk}, 64'd1);
        cycles_to_tick(20, n);
        chk("tick_gap_a", 64'(n), 64'd4);
        chk("fall_level", {63'd0, oclk}, 64'd0);
        cycles_to_tick(20, n);
        chk("tick_gap_b", 64'(n), 64'd4);
        cycles_to_tick(20, n);
        chk("tick_gap_c", 64'(n), 64'd4);

        // stop during the low phase: parked on the next edge with no tick
        ienable = 1'b0;
        @(negedge iclk);
        chk("low_stop_state", {62'd0, ostate}, 64'd0);
        chk("low_stop_tick",  {63'd0, otick},  64'd0);

        // zero request in IDLE clamps to 1, visible two edges later
        ivalid = 1'b1;
        ihalf  = '0;
        @(negedge iclk);
        ivalid = 1'b0;
        chk("req0_ready_low", {63'd0, oready}, 64'd0);
        chk("req0_half_old",  {32'd0, ohalf},  64'd4);
        @(negedge iclk);
        chk("req0_half_new",  {32'd0, ohalf},  64'd1);
        chk("req0_ready_still_low", {63'd0, oready}, 64'd0);
        @(negedge iclk);
        chk("req0_ready_back", {63'd0, oready}, 64'd1);
        ienable = 1'b1;
        @(negedge iclk);
        prev = oclk;
        for (int i = 0; i < 6; i++) begin
            @(negedge iclk);
            chk("half1_tick", {63'd0, otick}, 64'd1);
            chk("half1_toggle", {63'd0, oclk}, {63'd0, ~prev});
            prev = oclk;
        end

        // back to half 4 from IDLE
        ienable = 1'b0;
        wait_idle(20);
        ivalid = 1'b1;
        ihalf  = 32'd4;
        @(negedge iclk);
        ivalid = 1'b0;
        repeat (3) @(negedge iclk);
        chk("restore_half", {32'd0, ohalf}, 64'd4);

        // stop requested at count 1 of a high phase
        ienable = 1'b1;
        cycles_to_tick(20, n);
        @(negedge iclk);
        ienable = 1'b0;
        @(negedge iclk);
        chk("stopping_state_a", {62'd0, ostate}, 64'd2);
        chk("stopping_clk_a",   {63'd0, oclk},   64'd1);
        @(negedge iclk);
        chk("stopping_state_b", {62'd0, ostate}, 64'd2);
        @(negedge iclk);
        chk("stop_fall_clk",   {63'd0, oclk},   64'd0);
        chk("stop_fall_tick",  {63'd0, otick},  64'd1);
        chk("stop_fall_state", {62'd0, ostate}, 64'd0);
        @(negedge iclk);
        chk("stop_after_tick", {63'd0, otick}, 64'd0);

        // request accepted exactly on a boundary edge
        ienable = 1'b1;
        cycles_to_tick(20, n);
        repeat (3) @(negedge iclk);
        ivalid = 1'b1;
        ihalf  = 32'd2;
        @(negedge iclk);
        ivalid = 1'b0;
        chk("bnd_req_tick", {63'd0, otick}, 64'd1);
        chk("bnd_req_half_old", {32'd0, ohalf}, 64'd4);
        cycles_to_tick(20, n);
        chk("bnd_req_old_len", 64'(n), 64'd4);
        chk("bnd_req_half_new", {32'd0, ohalf}, 64'd2);
        cycles_to_tick(20, n);
        chk("bnd_req_new_len", 64'(n), 64'd2);
        chk("bnd_req_ready", {63'd0, oready}, 64'd1);

        // asynchronous reset while high
        n = 0;
        while (!oclk && n < 10) begin
            @(negedge iclk);
            n++;
        end
        #2 irst_n = 1'b0;
        #1;
        chk("arst_clk",   {63'd0, oclk},   64'd0);
        chk("arst_tick",  {63'd0, otick},  64'd0);
        chk("arst_ready", {63'd0, oready}, 64'd1);
        chk("arst_half",  {32'd0, ohalf},  64'd4);
        chk("arst_state", {62'd0, ostate}, 64'd0);
        @(negedge iclk);
        #2 irst_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            @(negedge iclk);
            if ($urandom_range(19) == 0) ienable = ~ienable;
            ivalid = ($urandom_range(5) == 0);
            ihalf  = WIDTH'($urandom_range(6));
            if ($urandom_range(999) == 0) begin
                #2 irst_n = 1'b0;
                @(negedge iclk);
                #2 irst_n = 1'b1;
            end
        end
        ivalid = 1'b0;
        @(negedge iclk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
